// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// DIGIT-bit combinational ripple adder slice.
module adder_slice #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic c;

  always_comb begin
    c        = ci;
    c_msb_in = ci;
    s        = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb_in = c;
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: one DIGIT-wide slice, LSB digit first,
// start/ready/done handshake, carry-out and signed overflow.
module serial_addsub
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = cnt_w(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  generate
    if ((WIDTH % DIGIT) != 0 || NDIG < 1) begin : g_chk
      $error("serial_addsub: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  state_t state, state_nx;

  logic [WIDTH-1:0] ra, rb, acc, acc_nx;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [DIGIT-1:0] s;
  logic             co, cm, last;

  adder_slice #(.DIGIT(DIGIT)) u_slice (
    .x        (ra[DIGIT-1:0]),
    .y        (rb[DIGIT-1:0]),
    .ci       (carry),
    .s        (s),
    .co       (co),
    .c_msb_in (cm)
  );

  assign last   = (cnt == LAST);
  // New digit enters at the top; after NDIG shifts it sits in place.
  assign acc_nx = (acc >> DIGIT) | (WIDTH'(s) << (WIDTH - DIGIT));
  assign ready  = (state == ST_IDLE);
  assign done   = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN:  if (last)  state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra    <= '0;
      rb    <= '0;
      acc   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      ra    <= a;
      rb    <= sub ? ~b : b;
      carry <= cin ^ sub;
      cnt   <= '0;
    end else if (state == ST_RUN) begin
      ra    <= ra >> DIGIT;
      rb    <= rb >> DIGIT;
      acc   <= acc_nx;
      carry <= co;
      cnt   <= cnt + 1'b1;
      if (last) begin
        sum  <= acc_nx;
        cout <= co;
        ovf  <= co ^ cm;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed scoreboard bench for serial_addsub in three configurations.
module tb_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  st, sb, ci, rdy, dn, co, ov;
  logic [31:0] a0, b0, s0, a2, b2, s2;
  logic [7:0]  a1, b1, s1;

  serial_addsub #(.WIDTH(32), .DIGIT(8)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sb[0]),
    .a(a0), .b(b0), .cin(ci[0]), .ready(rdy[0]), .done(dn[0]),
    .sum(s0), .cout(co[0]), .ovf(ov[0]));

  serial_addsub #(.WIDTH(8), .DIGIT(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sb[1]),
    .a(a1), .b(b1), .cin(ci[1]), .ready(rdy[1]), .done(dn[1]),
    .sum(s1), .cout(co[1]), .ovf(ov[1]));

  serial_addsub #(.WIDTH(32), .DIGIT(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .sub(sb[2]),
    .a(a2), .b(b2), .cin(ci[2]), .ready(rdy[2]), .done(dn[2]),
    .sum(s2), .cout(co[2]), .ovf(ov[2]));

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int wid(input int d);
    return (d == 1) ? 8 : 32;
  endfunction

  function automatic int nd(input int d);
    return (d == 0) ? 4 : (d == 1) ? 1 : 32;
  endfunction

  function automatic logic [31:0] gsum(input int d);
    return (d == 0) ? s0 : (d == 1) ? {24'd0, s1} : s2;
  endfunction

  function automatic exp_t model(input int d, input logic s,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic c);
    exp_t        e;
    int          w;
    logic [63:0] mask, ea, eb, full, low, c0;
    w    = wid(d);
    mask = (64'd1 << w) - 64'd1;
    ea   = {32'd0, a} & mask;
    eb   = (s ? ~{32'd0, b} : {32'd0, b}) & mask;
    c0   = {63'd0, c ^ s};
    full = ea + eb + c0;
    low  = (ea & (mask >> 1)) + (eb & (mask >> 1)) + c0;
    e.sum  = full[31:0] & mask[31:0];
    e.cout = full[w];
    e.ovf  = low[w-1] ^ full[w];
    return e;
  endfunction

  task automatic drive(input int d, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic c);
    sb[d] = s;
    ci[d] = c;
    case (d)
      0: begin a0 = a; b0 = b; end
      1: begin a1 = a[7:0]; b1 = b[7:0]; end
      default: begin a2 = a; b2 = b; end
    endcase
  endtask

  task automatic run(input int d, input logic s, input logic [31:0] a,
                     input logic [31:0] b, input logic c, input string tag);
    exp_t        e;
    int          lat;
    logic [31:0] prev;
    logic        held;
    @(negedge clk);
    drive(d, s, a, b, c);
    st[d] = 1'b1;
    q.push_back(model(d, s, a, b, c));
    prev = gsum(d);
    @(posedge clk);
    #1;
    st[d] = 1'b0;
    drive(d, ~s, $urandom, $urandom, ~c);
    check({tag, " ready_low"}, {31'd0, rdy[d]}, 32'd0);
    lat  = 0;
    held = 1'b1;
    while (!dn[d] && lat < 100) begin
      if (gsum(d) !== prev) held = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " held"}, {31'd0, held}, 32'd1);
    check({tag, " latency"}, lat, nd(d));
    e = q.pop_front();
    check({tag, " sum"}, gsum(d), e.sum);
    check({tag, " cout"}, {31'd0, co[d]}, {31'd0, e.cout});
    check({tag, " ovf"}, {31'd0, ov[d]}, {31'd0, e.ovf});
    @(posedge clk);
    #1;
    check({tag, " done_end"}, {31'd0, dn[d]}, 32'd0);
    check({tag, " ready_end"}, {31'd0, rdy[d]}, 32'd1);
  endtask

  initial begin
    logic [15:0] mask;
    logic        seen;
    st = '0; sb = '0; ci = '0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst ready", {29'd0, rdy}, 32'h7);
    check("rst done", {29'd0, dn}, 32'h0);
    check("rst sum", s0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    run(0, 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0, "add_wrap");
    check("add_wrap literal", s0, 32'h0);
    check("add_wrap cout lit", {31'd0, co[0]}, 32'd1);
    run(0, 1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0, "ovf_pos");
    check("ovf_pos literal", {s0[31], ov[0]}, 32'd3);
    run(0, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, "ovf_neg");
    run(0, 1'b1, 32'd7, 32'd5, 1'b0, "sub_7_5");
    check("sub_7_5 literal", s0, 32'd2);
    run(0, 1'b1, 32'd5, 32'd7, 1'b0, "sub_5_7");
    check("sub_5_7 literal", s0, 32'hFFFF_FFFE);
    run(0, 1'b1, 32'h8000_0000, 32'd1, 1'b0, "sub_min");
    check("sub_min literal", s0, 32'h7FFF_FFFF);
    run(0, 1'b0, 32'h10, 32'h20, 1'b1, "add_cin");
    check("add_cin literal", s0, 32'h31);
    run(0, 1'b1, 32'h10, 32'h05, 1'b1, "sub_cin");
    check("sub_cin literal", s0, 32'h0A);

    // start held high: accepts at edges 0 and 6 only
    @(negedge clk);
    drive(0, 1'b0, 32'd1, 32'd2, 1'b0);
    st[0] = 1'b1;
    mask  = '0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      mask[k] = dn[0];
      if (k == 11) st[0] = 1'b0;
    end
    check("held_start done_edges", {16'd0, mask}, 32'h0410);
    check("held_start sum", s0, 32'd3);
    repeat (4) @(posedge clk);

    // reset in the second RUN cycle aborts the op silently
    @(negedge clk);
    drive(0, 1'b0, 32'h55, 32'h11, 1'b0);
    st[0] = 1'b1;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst ready", {31'd0, rdy[0]}, 32'd1);
    check("mid_rst done", {31'd0, dn[0]}, 32'd0);
    check("mid_rst sum", s0, 32'd0);
    check("mid_rst cout_ovf", {30'd0, co[0], ov[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (dn[0]) seen = 1'b1;
    end
    check("mid_rst no_done", {31'd0, seen}, 32'd0);
    run(0, 1'b0, 32'd3, 32'd4, 1'b0, "post_rst");
    check("post_rst literal", s0, 32'd7);

    run(1, 1'b0, 32'hFF, 32'h01, 1'b0, "w8_add");
    check("w8_add literal", {30'd0, co[1], ov[1]}, 32'd2);
    run(1, 1'b1, 32'h80, 32'h01, 1'b0, "w8_sub");
    run(2, 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0, "d1_add");
    run(2, 1'b1, 32'd5, 32'd7, 1'b0, "d1_sub");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised, multi-cycle, digit-serial adder/subtractor for the datapath. It processes a WIDTH-bit operand pair DIGIT bits per clock, LSB digit first, through a single DIGIT-wide ripple slice, trading latency for area. It reports carry-out and signed overflow and uses a start/ready/done handshake toward the controlling FSM.

## Interface
- WIDTH, 32, operand and result width; must be a multiple of DIGIT.
- DIGIT, 8, bits processed per cycle; NDIG = WIDTH/DIGIT (NDIG ≥ 1).

Clock and reset: one clock, `clk`; reset `rst_n`, asynchronous, active-low.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when ready=1.
- sub  in  1  0: a+b+cin; 1: a−b−cin.
- a  in  WIDTH  operand A, sampled on accept.
- b  in  WIDTH  operand B, sampled on accept.
- cin  in  1  carry-in (add) / borrow-in (sub), sampled on accept.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse: result valid.
- sum  out  WIDTH  result.
- cout  out  1  raw carry out of the MSB. For sub, 1 = no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE → RUN (exactly NDIG cycles) → DONE (1 cycle) → IDLE.
- Accept (IDLE, start=1):
  - latch a into operand shift register A.
  - latch b, or ~b if sub=1, into operand shift register B.
  - set carry register to cin XOR sub.
  - clear digit counter.
- Subtraction identity: a − b − cin = a + ~b + ~cin.
- RUN, per cycle:
  - slice adds low DIGIT bits of A and B plus the carry register.
  - slice output shifts into the top of the partial-result register.
  - A and B shift right by DIGIT.
  - carry register takes the slice carry-out.
  - counter increments.
- The last RUN cycle also captures the carry into the slice MSB, for ovf.
- On leaving RUN, sum, cout and ovf load from the partial-result register and carries.
  - These outputs change only on that edge.
  - They hold through DONE and IDLE until the next result is written.
- start while ready=0 is ignored: no queuing, no effect on the current operation.
- Inputs a, b, sub and cin may change freely after the accepting edge.
- Reset (any time, including mid-RUN):
  - state=IDLE, ready=1, done=0, sum=0, cout=0, ovf=0.
  - counter and internal registers cleared.
  - no done is produced for the aborted operation.

## Timing
- Let T be the rising edge where start=1 and ready=1.
- ready goes low after T. RUN covers edges T+1 … T+NDIG, digit i processed at edge T+1+i.
- Edge T+NDIG: final digit processed, results registered, state→DONE, done=1.
- done is high exactly between edges T+NDIG and T+NDIG+1.
- Edge T+NDIG+1: state→IDLE, done=0, ready=1.
- Earliest next accept: edge T+NDIG+2. Throughput: one op per NDIG+2 cycles.
- NDIG=1: RUN lasts one cycle; same rules apply.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `adder_pkg`:
  - FSM state encodings (ST_IDLE, ST_RUN, ST_DONE).
  - NDIG computation.
  - counter width $clog2(NDIG)+1.
- Sub-module `adder_slice`: parametrised DIGIT-bit combinational ripple adder.
  - ports: x, y, ci, s, co, and c_msb_in (carry into MSB).
  - instantiated once.
- Top level holds the FSM, shift registers, counter and output registers.
- Elaboration-time check: WIDTH % DIGIT == 0.

## Test plan
Default config is WIDTH=32, DIGIT=8 unless stated.
1. Add 0xFFFF_FFFF + 0x0000_0001, cin=0 → sum=0x0000_0000, cout=1, ovf=0. done exactly 4 edges after accept, ready high again on the following edge.
2. Signed overflow: 0x7FFF_FFFF + 0x0000_0001 → sum=0x8000_0000, cout=0, ovf=1. Then 0x8000_0000 + 0x8000_0000 → sum=0, cout=1, ovf=1.
3. Subtract:
   - 7−5 → sum=0x0000_0002, cout=1, ovf=0.
   - 5−7 → sum=0xFFFF_FFFE, cout=0, ovf=0.
   - 0x8000_0000−1 → sum=0x7FFF_FFFF, ovf=1.
4. Carry/borrow-in:
   - 0x10+0x20, cin=1 → 0x31.
   - 0x10−0x05, cin=1 (sub) → 0x0A.
5. Handshake:
   - start held high continuously → ops accepted only at edges T and T+6; done pulses once per op.
   - operands changed mid-RUN → result unaffected.
   - previous sum held until the next done.
6. Reset and edge configs:
   - rst_n low during the 2nd RUN cycle → immediately ready=1, done=0, sum=0, cout=0, ovf=0, no done pulse.
   - next op 3+4 → sum=7.
   - repeat test 1 with WIDTH=8, DIGIT=8 (NDIG=1: done 1 edge after accept) and WIDTH=32, DIGIT=1 (done 32 edges after accept).
